// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode stage, the ALU issue stage and the ALU.
// The upstream side uses in_* and the downstream side uses out_*. Each side
// has its own valid/ready pair.
interface alu_issue_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_alu_op;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_rs_val;
    logic [DATA_W-1:0] in_rt_val;
    logic [IMM_W-1:0]  in_imm;
    logic              in_alu_src;
    logic [4:0]        in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [3:0]        out_alu_control;
    logic [4:0]        out_rd;
    logic              out_illegal;

    // The environment drives instructions in and the ALU-side ready.
    modport master (
        output in_valid, in_alu_op, in_funct, in_rs_val, in_rt_val, in_imm,
               in_alu_src, in_rd, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_control, out_rd,
               out_illegal
    );

    // The issue stage consumes instructions and presents operands.
    modport slave (
        input  in_valid, in_alu_op, in_funct, in_rs_val, in_rt_val, in_imm,
               in_alu_src, in_rd, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_control, out_rd,
               out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage. It decodes alu_op/funct into the 4-bit ALU control code and
// selects operand B from rt or the extended immediate. The result goes into a
// two-entry skid buffer.
//
// State | meaning
// ------+---------------------------------------------------------------
// EMPTY | nothing held, out_valid low, in_ready high
// MAIN  | main entry presented on out_*, skid empty, in_ready high
// FULL  | main presented and skid holds the next entry, in_ready low
//
// in_ready is a flop. It has no combinational path from out_ready, so an
// instruction that arrives while MAIN is stalled still needs a place to go.
// The skid entry provides that place.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);

    typedef enum logic [1:0] {EMPTY, MAIN, FULL} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        ctrl;
        logic [4:0]        rd;
        logic              illegal;
    } entry_t;

    state_t            state;
    entry_t            main_q;
    entry_t            skid_q;
    entry_t            new_entry;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              accept;
    logic [DATA_W-1:0] ext_imm;

    assign accept = bus.in_valid && in_ready_q;

    // Decode the incoming instruction into a buffer entry.
    // ori zero-extends its immediate. Every other op sign-extends it.
    always_comb begin
        new_entry = '0;
        if (bus.in_alu_op == 2'b11)
            ext_imm = {{(DATA_W-IMM_W){1'b0}}, bus.in_imm};
        else
            ext_imm = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};

        new_entry.a  = bus.in_rs_val;
        new_entry.b  = bus.in_alu_src ? ext_imm : bus.in_rt_val;
        new_entry.rd = bus.in_rd;

        case (bus.in_alu_op)
            2'b00: new_entry.ctrl = 4'b0010;
            2'b01: new_entry.ctrl = 4'b0110;
            2'b11: new_entry.ctrl = 4'b0001;
            default: begin
                case (bus.in_funct)
                    6'b100000: new_entry.ctrl = 4'b0010;
                    6'b100010: new_entry.ctrl = 4'b0110;
                    6'b100100: new_entry.ctrl = 4'b0000;
                    6'b100101: new_entry.ctrl = 4'b0001;
                    6'b100111: new_entry.ctrl = 4'b1100;
                    6'b101010: new_entry.ctrl = 4'b0111;
                    default: begin
                        // An unsupported funct still flows through. The flag
                        // tells the consumer to trap on it.
                        new_entry.ctrl    = 4'b0000;
                        new_entry.illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Skid-buffer state machine with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= new_entry;
                        out_valid_q <= 1'b1;
                        state       <= MAIN;
                    end
                end
                MAIN: begin
                    if (accept && bus.out_ready) begin
                        main_q <= new_entry;
                    end else if (accept) begin
                        skid_q     <= new_entry;
                        in_ready_q <= 1'b0;
                        state      <= FULL;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= MAIN;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_a           = main_q.a;
    assign bus.out_b           = main_q.b;
    assign bus.out_alu_control = main_q.ctrl;
    assign bus.out_rd          = main_q.rd;
    assign bus.out_illegal     = main_q.illegal;

endmodule
